// File: rtl/knapsack_pkg.sv
// knapsack_pkg: shared FSM states, default sizes and the latched job record
package knapsack_pkg;
    localparam int ITEMS_D = 8;
    localparam int FW_D = 4;
    typedef enum logic [2:0] {IDLE, CHECK, LAUNCH, WAIT, RESP} state_t;
    typedef struct packed {
        logic [FW_D-1:0]         N;
        logic [FW_D-1:0]         W;
        logic [ITEMS_D*FW_D-1:0] w;
        logic [ITEMS_D*FW_D-1:0] p;
    } job_t;
endpackage

// File: rtl/knapsack_rr_grant.sv
// knapsack_rr_grant: two-way round-robin grant; after a grant the other side is preferred
module knapsack_rr_grant (
    input  logic clk,
    input  logic reset,
    input  logic v0,
    input  logic v1,
    input  logic en,
    output logic g0,
    output logic g1
);
    logic ptr;
    assign g0 = en && v0 && (!v1 || !ptr);
    assign g1 = en && v1 && (!v0 || ptr);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= 1'b0;
        else if (g0 || g1)
            ptr <= g0;
    end
endmodule

// File: rtl/knapsack_job_arbiter.sv
// knapsack_job_arbiter: shares one knapsack solver between two requesters.
// Define KNAPSACK_ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYC cycles.
module knapsack_job_arbiter
    import knapsack_pkg::*;
#(
    parameter int ITEMS = ITEMS_D,
    parameter int FW = FW_D,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [FW-1:0]       req0_N,
    input  logic [FW-1:0]       req0_W,
    input  logic [ITEMS*FW-1:0] req0_w,
    input  logic [ITEMS*FW-1:0] req0_p,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [FW-1:0]       req1_N,
    input  logic [FW-1:0]       req1_W,
    input  logic [ITEMS*FW-1:0] req1_w,
    input  logic [ITEMS*FW-1:0] req1_p,
    output logic                rsp0_valid,
    output logic [ITEMS-1:0]    rsp0_out,
    output logic                rsp0_err,
    output logic                rsp1_valid,
    output logic [ITEMS-1:0]    rsp1_out,
    output logic                rsp1_err,
    output logic [FW-1:0]       slv_N,
    output logic [FW-1:0]       slv_W,
    output logic [ITEMS*FW-1:0] slv_w,
    output logic [ITEMS*FW-1:0] slv_p,
    output logic                slv_R_I,
    input  logic [ITEMS-1:0]    slv_out,
    input  logic                slv_R_O,
    input  logic                slv_Error
);
    state_t           state, state_d;
    job_t             job;
    logic             owner;
    logic [ITEMS-1:0] res;
    logic             err;
    logic             n_ok, hs, tmo, drive;

    knapsack_rr_grant u_grant (
        .clk  (clk),
        .reset(reset),
        .v0   (req0_valid),
        .v1   (req1_valid),
        .en   (state == IDLE),
        .g0   (req0_ready),
        .g1   (req1_ready)
    );

    assign hs = req0_ready || req1_ready;
    assign n_ok = job.N != '0 && int'(job.N) <= ITEMS;

`ifdef KNAPSACK_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (state == LAUNCH)
            cnt <= '0;
        else if (state == WAIT)
            cnt <= cnt + CW'(1);
    end
    assign tmo = cnt == CW'(TIMEOUT_CYC - 1);
`else
    // watchdog absent: never expires
    assign tmo = TIMEOUT_CYC < 0;
`endif

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    state_d = hs ? CHECK : IDLE;
            CHECK:   state_d = n_ok ? LAUNCH : RESP;
            LAUNCH:  state_d = WAIT;
            WAIT:    state_d = (slv_R_O || tmo) ? RESP : WAIT;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            job   <= '0;
            owner <= 1'b0;
            res   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            if (hs) begin
                job   <= req1_ready ? {req1_N, req1_W, req1_w, req1_p} : {req0_N, req0_W, req0_w, req0_p};
                owner <= req1_ready;
            end
            // solver completion beats a coincident watchdog expiry
            if (state == CHECK && !n_ok) begin
                res <= '0;
                err <= 1'b1;
            end else if (state == WAIT && slv_R_O) begin
                res <= slv_out;
                err <= slv_Error;
            end else if (state == WAIT && tmo) begin
                res <= '0;
                err <= 1'b1;
            end
        end
    end

    assign drive = state == LAUNCH || state == WAIT || (state == CHECK && n_ok);
    assign slv_N = drive ? job.N : '0;
    assign slv_W = drive ? job.W : '0;
    assign slv_w = drive ? job.w : '0;
    assign slv_p = drive ? job.p : '0;
    assign slv_R_I = state == LAUNCH;

    assign rsp0_valid = state == RESP && !owner;
    assign rsp1_valid = state == RESP && owner;
    assign rsp0_out = rsp0_valid ? res : '0;
    assign rsp1_out = rsp1_valid ? res : '0;
    assign rsp0_err = rsp0_valid && err;
    assign rsp1_err = rsp1_valid && err;
endmodule

// File: tb/tb_knapsack_job_arbiter.sv
// tb_knapsack_job_arbiter: scoreboard bench with a solver model and a reference arbiter model
module tb_knapsack_job_arbiter;
    localparam int TO = 255;

    typedef struct {
        bit         side;
        logic [7:0] out;
        bit         err;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [3:0]  n;
        logic [3:0]  wc;
        logic [31:0] w;
        logic [31:0] p;
        logic [7:0]  out;
        bit          err;
        int          lat;
        int          lcyc;
    } sj_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  v = '0;
    logic [3:0]  n[2];
    logic [3:0]  wc[2];
    logic [31:0] ww[2];
    logic [31:0] pp[2];
    logic [7:0]  pend_out[2];
    bit          pend_err[2];
    int          pend_lat[2];
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [7:0]  rsp0_out, rsp1_out;
    logic [3:0]  slv_N, slv_W;
    logic [31:0] slv_w, slv_p;
    logic        slv_R_I;
    logic        ro_m = 1'b0, ro_spur = 1'b0, serr = 1'b0;
    logic [7:0]  sout = '0;

    exp_t sb[$];
    sj_t  sq[$];
    int   cyc = 0, busy_until = -1, rst_cnt = 0, errors = 0, checks = 0;
    bit   ptr = 1'b0;
    logic prev_ri = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge reset) rst_cnt++;

    knapsack_job_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(v[0]),
        .req0_ready(req0_ready),
        .req0_N    (n[0]),
        .req0_W    (wc[0]),
        .req0_w    (ww[0]),
        .req0_p    (pp[0]),
        .req1_valid(v[1]),
        .req1_ready(req1_ready),
        .req1_N    (n[1]),
        .req1_W    (wc[1]),
        .req1_w    (ww[1]),
        .req1_p    (pp[1]),
        .rsp0_valid(rsp0_valid),
        .rsp0_out  (rsp0_out),
        .rsp0_err  (rsp0_err),
        .rsp1_valid(rsp1_valid),
        .rsp1_out  (rsp1_out),
        .rsp1_err  (rsp1_err),
        .slv_N     (slv_N),
        .slv_W     (slv_W),
        .slv_w     (slv_w),
        .slv_p     (slv_p),
        .slv_R_I   (slv_R_I),
        .slv_out   (sout),
        .slv_R_O   (ro_m | ro_spur),
        .slv_Error (serr)
    );

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic fail(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, {req1_ready, req0_ready}, 0);
        chk({tag, "_rsp0"}, {rsp0_valid, rsp0_err, rsp0_out}, 0);
        chk({tag, "_rsp1"}, {rsp1_valid, rsp1_err, rsp1_out}, 0);
        chk({tag, "_slv_nw"}, {slv_R_I, slv_N, slv_W}, 0);
        chk({tag, "_slv_w"}, slv_w, 0);
        chk({tag, "_slv_p"}, slv_p, 0);
    endtask

    // reference: one job in flight, round-robin between simultaneous requesters
    always @(negedge clk) begin : mon
        exp_t e;
        sj_t  j;
        bit   g0, g1, idle, s, bad;
        int   lat;
        if (reset) begin
            sb.delete();
            sq.delete();
            busy_until = -1;
            ptr = 1'b0;
            prev_ri = 1'b0;
        end else begin
            if (slv_R_I) chk("ri_width", prev_ri, 0);
            prev_ri = slv_R_I;
            if (rsp0_valid || rsp1_valid) begin
                if (sb.size() == 0) begin
                    fail("rsp_unexpected", {rsp1_valid, rsp0_valid}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", {rsp1_valid, rsp0_valid}, e.side ? 2'b10 : 2'b01);
                    chk("rsp_out", e.side ? rsp1_out : rsp0_out, e.out);
                    chk("rsp_err", e.side ? rsp1_err : rsp0_err, e.err);
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
                fail("rsp_missing", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            idle = cyc > busy_until;
            g0 = idle && v[0] && (!v[1] || !ptr);
            g1 = idle && v[1] && (!v[0] || ptr);
            chk("ready0", req0_ready, g0);
            chk("ready1", req1_ready, g1);
            if (g0 || g1) begin
                s = g1;
                bad = n[s] == 0 || n[s] > 8;
                e.side = s;
                if (bad) begin
                    e.out = 0;
                    e.err = 1'b1;
                    e.cyc = cyc + 2;
                end else begin
                    lat = pend_lat[s];
                    e.out = pend_out[s];
                    e.err = pend_err[s];
`ifdef KNAPSACK_ARB_TIMEOUT_EN
                    if (lat > TO) begin
                        lat = TO;
                        e.out = 0;
                        e.err = 1'b1;
                    end
`endif
                    e.cyc = cyc + 3 + lat;
                    j = '{n[s], wc[s], ww[s], pp[s], pend_out[s], pend_err[s], pend_lat[s], cyc + 2};
                    sq.push_back(j);
                end
                sb.push_back(e);
                busy_until = e.cyc;
                ptr = !s;
            end
        end
    end

    // solver model: answers lat cycles after the start strobe (lat >= 1000 never answers)
    initial begin : solver
        sj_t j;
        int  rc;
        forever begin
            @(negedge clk);
            if (!reset && slv_R_I) begin
                if (sq.size() == 0) begin
                    fail("launch_unexpected", 1, 0);
                end else begin
                    j = sq.pop_front();
                    rc = rst_cnt;
                    chk("launch_cycle", cyc, j.lcyc);
                    chk("slv_NW", {slv_N, slv_W}, {j.n, j.wc});
                    chk("slv_w", slv_w, j.w);
                    chk("slv_p", slv_p, j.p);
                    if (j.lat < 1000) begin
                        repeat (j.lat) @(posedge clk);
                        #1;
                        if (rc == rst_cnt) chk("hold_slv", {slv_N, slv_W, slv_w, slv_p}, {j.n, j.wc, j.w, j.p});
                        ro_m = 1'b1;
                        sout = j.out;
                        serr = j.err;
                        @(posedge clk);
                        #1;
                        ro_m = 1'b0;
                        sout = '0;
                        serr = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input int s, input logic [3:0] nn, input logic [3:0] cap, input logic [31:0] wz,
                        input logic [31:0] pz, input int maxw, input bit must);
        bit got = 1'b0;
        n[s] = nn;
        wc[s] = cap;
        ww[s] = wz;
        pp[s] = pz;
        v[s] = 1'b1;
        for (int i = 0; i < maxw && !got; i++) begin
            @(negedge clk);
            got = (s != 0) ? req1_ready : req0_ready;
        end
        if (!got && must) fail("grant_timeout", 0, 1);
        @(posedge clk);
        #1;
        v[s] = 1'b0;
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((sb.size() != 0 || cyc <= busy_until) && i < 3000) begin
            @(posedge clk);
            i++;
        end
        if (i >= 3000) fail("idle_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input int s);
        for (int j = 0; j < 25; j++) begin
            int  g = $urandom_range(0, 3);
            bit  blip = $urandom_range(0, 9) == 0;
            logic [3:0] nn;
            if (g != 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            pend_out[s] = 8'($urandom);
            pend_err[s] = $urandom_range(0, 7) == 0;
            pend_lat[s] = $urandom_range(1, 12);
            nn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
            send(s, nn, 4'($urandom), $urandom, $urandom, blip ? 1 : 300, !blip);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            n[i] = '0;
            wc[i] = '0;
            ww[i] = '0;
            pp[i] = '0;
            pend_out[i] = '0;
            pend_err[i] = 1'b0;
            pend_lat[i] = 1;
        end
        repeat (3) @(negedge clk);
        #1 chk_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        pend_out[0] = 8'hA5;
        pend_err[0] = 1'b0;
        pend_lat[0] = 10;
        send(0, 4'd5, 4'd7, 32'h00006132, 32'h00013245, 20, 1'b1);
        wait_idle();
        for (int r = 0; r < 2; r++) begin
            pend_out[0] = 8'h3C;
            pend_lat[0] = 2;
            pend_out[1] = 8'hC3;
            pend_lat[1] = 4;
            fork
                send(0, 4'd3, 4'd9, 32'h00000123, 32'h00000456, 100, 1'b1);
                send(1, 4'd8, 4'd15, 32'h12345678, 32'h87654321, 100, 1'b1);
            join
            wait_idle();
        end
        send(1, 4'd0, 4'd5, 32'h11111111, 32'h22222222, 20, 1'b1);
        wait_idle();
        send(1, 4'd9, 4'd5, 32'h33333333, 32'h44444444, 20, 1'b1);
        wait_idle();
        pend_out[0] = 8'h00;
        pend_err[0] = 1'b1;
        pend_lat[0] = 3;
        send(0, 4'd8, 4'd12, 32'hFEDCBA98, 32'h01234567, 20, 1'b1);
        wait_idle();
        pend_out[1] = 8'h01;
        pend_err[1] = 1'b0;
        pend_lat[1] = 1;
        send(1, 4'd1, 4'd1, 32'h00000001, 32'h0000000F, 20, 1'b1);
        wait_idle();
        pend_out[0] = 8'hFF;
        pend_err[0] = 1'b0;
        pend_lat[0] = 20;
        send(0, 4'd4, 4'd6, 32'h00004321, 32'h00001234, 20, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_zero("reset_mid");
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        #1 ro_spur = 1'b1;
        @(posedge clk);
        #1 ro_spur = 1'b0;
        fork
            drive_rand(0);
            drive_rand(1);
        join
        wait_idle();
`ifdef KNAPSACK_ARB_TIMEOUT_EN
        pend_out[1] = 8'h5A;
        pend_err[1] = 1'b0;
        pend_lat[1] = 1000;
        send(1, 4'd3, 4'd4, 32'h00000321, 32'h00000777, 20, 1'b1);
        wait_idle();
`endif
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/knapsack_job_arbiter.md
Name: knapsack_job_arbiter

Overview:
- Shares one knapsack solver `fsm` between two requesters.
- Accepts jobs (item count, capacity, packed weights, packed profits) and grants round-robin.
- Latches operands, launches the solver and waits for its ready strobe.
- Returns the selection mask and error flag to the requester that owns the job.
- Sits between the host-side job sources and the single solver instance.

Parameters:
- ITEMS, 8, maximum item count; sets the number of packed fields and the mask width.
- FW, 4, bit width of each packed weight/profit field and of N and W.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a job
- req0_ready  out  1  job accepted this cycle (valid&ready)
- req0_N  in  FW  item count
- req0_W  in  FW  knapsack capacity
- req0_w  in  ITEMS*FW  packed weights, item 0 in the LSBs
- req0_p  in  ITEMS*FW  packed profits, item 0 in the LSBs
- req1_valid, req1_ready, req1_N, req1_W, req1_w, req1_p: same as requester 0
- rsp0_valid  out  1  one-cycle response strobe to requester 0
- rsp0_out  out  ITEMS  selection mask
- rsp0_err  out  1  error flag for requester 0
- rsp1_valid, rsp1_out, rsp1_err: same as requester 0
- slv_N  out  FW  to solver N
- slv_W  out  FW  to solver W
- slv_w  out  ITEMS*FW  to solver w
- slv_p  out  ITEMS*FW  to solver p
- slv_R_I  out  1  solver start strobe
- slv_out  in  ITEMS  solver result
- slv_R_O  in  1  solver done
- slv_Error  in  1  solver error

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0, the state goes to IDLE and the RR pointer goes to 0 (requester 0 preferred).
- IDLE:
  - If exactly one req valid, grant it.
  - If both are valid, grant the pointer side and flip the pointer after the grant.
  - req*_ready is combinational: high only in IDLE, for the granted side.
  - On the handshake, latch N, W, w, p and the owner id. Go to CHECK.
- CHECK (1 cycle):
  - If N==0 or N>ITEMS, go to RESP with err=1 and out=0. The solver is not launched.
  - Otherwise drive slv_* from the latches and go to LAUNCH.
- LAUNCH (1 cycle):
  - slv_R_I=1.
  - slv_N/W/w/p are held stable from CHECK until leaving WAIT.
  - Go to WAIT.
- WAIT:
  - Hold slv_R_I=0.
  - On slv_R_O=1, capture slv_out and slv_Error and go to RESP.
- RESP (1 cycle):
  - The owner's rsp_valid=1 with the captured out/err; the other side's rsp stays 0.
  - Go to IDLE. No new grant occurs in the RESP cycle.
- slv_R_O outside WAIT (stale or spurious) is ignored.
- Minimum latency from handshake to rsp_valid: 4 cycles plus solver time (CHECK, LAUNCH, ≥1 WAIT, RESP).
- Validation error path: 2 cycles (CHECK, RESP).
- A requester deasserting valid without a handshake is not a job; nothing is latched.
- Back-to-back jobs are accepted; the earliest next accept is the cycle after RESP.
- Reset mid-job aborts the job. No response is issued, and a later slv_R_O is ignored because the state is IDLE.

Optional Feature:
- Macro: KNAPSACK_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYC+1) clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC with no slv_R_O, go to RESP with err=1 and out=0.
  - If slv_R_O and expiry occur in the same cycle, slv_R_O wins.
- Undefined: no counter; WAIT lasts indefinitely.

Decomposition:
- Package knapsack_pkg holds:
  - the state enum (IDLE, CHECK, LAUNCH, WAIT, RESP);
  - the ITEMS/FW defaults;
  - the job struct type {N, W, w, p}.
- Natural sub-module: knapsack_rr_grant, the two-way round-robin grant with pointer update on handshake.

Test Plan:
1. Job, normal path:
   - Stimulus: req0 with N=5, W=7, w=32'h00006132, p=32'h00013245; solver model asserts R_O 10 cycles after R_I with out=8'hA5, Error=0.
   - Response: slv_R_I high exactly 1 cycle. slv_* equal the latched values. rsp0_valid 1 cycle with out=8'hA5, err=0. rsp1_valid never asserts.
2. Simultaneous requests:
   - Stimulus: both valid right after reset.
   - Response: req0 is served first, then req1. A third simultaneous pair is served req0 first again (pointer alternates).
3. Invalid item count:
   - Stimulus: req1 with N=0, then with N=9.
   - Response: rsp1_valid 2 cycles after the handshake, err=1, out=0. slv_R_I stays 0.
4. Solver error:
   - Stimulus: model returns Error=1 with out=8'h00.
   - Response: the owner's rsp_err=1.
5. Reset mid-WAIT:
   - Stimulus: reset asserted during WAIT; model raises R_O later.
   - Response: all outputs 0 immediately. No rsp_valid. The state stays IDLE.
6. With KNAPSACK_ARB_TIMEOUT_EN:
   - Stimulus: model never asserts R_O.
   - Response: rsp_valid with err=1 after TIMEOUT_CYC WAIT cycles.
